alu_execute_unit: RTL and testbench

Execute-stage arithmetic unit that consumes the ALU decoder's `ALUControl`, `ALUSel` and `FlagWrite` outputs and the two scalar operands forwarded from the ID/EX register. It produces a registered result and maintains the NZCV flag register. Add, sub and shift ops complete in one cycle. Mul is an iterative shift-add over `WIDTH` cycles and stalls the pipeline through `ready`. Sits between the ID/EX pipeline register and the EX/MEM register; the hazard unit drives `flush` and observes `ready`.

---
 rtl/alu_execute_unit_if.sv | 28 ++
 rtl/alu_execute_unit.sv | 137 +++++++++++++
 tb/tb_alu_execute_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_execute_unit_if.sv
// Handshake and operand bundle between the ID/EX stage and the execute-stage ALU.
// The hazard unit drives flush and observes ready through the same bundle.
interface alu_execute_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [2:0]       ALUControl;
  logic             ALUSel;
  logic [1:0]       FlagWrite;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             flush;
  logic             ready;
  logic             out_valid;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlags;
  logic             illegal;

  modport master (
    output in_valid, ALUControl, ALUSel, FlagWrite, SrcA, SrcB, flush,
    input  ready, out_valid, ALUResult, ALUFlags, illegal
  );

  modport slave (
    input  in_valid, ALUControl, ALUSel, FlagWrite, SrcA, SrcB, flush,
    output ready, out_valid, ALUResult, ALUFlags, illegal
  );
endinterface

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU: single-cycle add/sub/shift, iterative shift-add multiply,
// registered result and NZCV flag register with per-pair write enables.
module alu_execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_execute_unit_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, result_q;
  logic [1:0]       fw_q;
  logic             out_valid_q, illegal_q;
  logic [3:0]       flags_q;

  logic             accept, is_illegal, is_mul, mul_last;
  logic [WIDTH-1:0] b_op, sum, single_res, acc_step;
  logic             carry, ovf, single_c, single_v;
  logic [SHW-1:0]   shamt;

  always_comb begin
    accept     = bus.in_valid && (state_q == IDLE) && !bus.flush;
    is_illegal = bus.ALUSel || (bus.ALUControl inside {3'b100, 3'b101, 3'b110});
    is_mul     = !is_illegal && (bus.ALUControl == OP_MUL);
    // Sub is A + ~B + 1, so the adder's carry out reads as "no borrow".
    b_op       = (bus.ALUControl == OP_SUB) ? ~bus.SrcB : bus.SrcB;
    {carry, sum} = {1'b0, bus.SrcA} + {1'b0, b_op}
                   + {{WIDTH{1'b0}}, (bus.ALUControl == OP_SUB)};
    ovf        = (bus.SrcA[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
    shamt      = bus.SrcB[SHW-1:0];
    single_res = '0;
    single_c   = 1'b0;
    single_v   = 1'b0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: begin
        single_res = sum;
        single_c   = carry;
        single_v   = ovf;
      end
      OP_SLL:  single_res = bus.SrcA << shamt;
      OP_SRL:  single_res = bus.SrcA >> shamt;
      default: single_res = '0;
    endcase
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_last = (cnt_q == SHW'(WIDTH - 1));
  end

  function automatic logic [3:0] upd_flags(input logic [3:0] old, input logic [WIDTH-1:0] res,
                                           input logic c, input logic v, input logic [1:0] fw);
    logic [3:0] nf;
    nf = old;
    if (fw[1]) begin
      nf[3] = res[WIDTH-1];
      nf[2] = (res == '0);
    end
    if (fw[0]) begin
      nf[1] = c;
      nf[0] = v;
    end
    return nf;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      fw_q        <= 2'b00;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand_q  <= bus.SrcA;
              mplier_q <= bus.SrcB;
              acc_q    <= '0;
              cnt_q    <= '0;
              fw_q     <= bus.FlagWrite;
              state_q  <= MUL;
            end else begin
              out_valid_q <= 1'b1;
              illegal_q   <= is_illegal;
              if (is_illegal) begin
                result_q <= '0;
              end else begin
                result_q <= single_res;
                flags_q  <= upd_flags(flags_q, single_res, single_c, single_v, bus.FlagWrite);
              end
            end
          end
        end
        MUL: begin
          // Flush beats completion, even on the final iteration.
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (mul_last) begin
              result_q    <= acc_step;
              flags_q     <= upd_flags(flags_q, acc_step, 1'b0, 1'b0, fw_q);
              out_valid_q <= 1'b1;
              illegal_q   <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = result_q;
  assign bus.ALUFlags  = flags_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed bench for alu_execute_unit: hand-computed vectors for arithmetic,
// flags, multiply latency, back-to-back stream, flush and asynchronous reset.
module tb_alu_execute_unit;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   bad;

  alu_execute_unit_if #(.WIDTH(32)) bus ();

  alu_execute_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] ctrl, input logic sel, input logic [1:0] fw,
                    input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = 1'b1;
    bus.ALUControl = ctrl;
    bus.ALUSel     = sel;
    bus.FlagWrite  = fw;
    bus.SrcA       = a;
    bus.SrcB       = b;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.ALUControl = 3'b000;
    bus.ALUSel     = 1'b0;
    bus.FlagWrite  = 2'b00;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.flush      = 1'b0;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.ALUResult, 32'h0);
    check("rst_flags", 32'(bus.ALUFlags), 32'h0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    reset = 1'b0;
    tick();

    // add with signed overflow
    op(3'b000, 1'b0, 2'b11, 32'h7FFF_FFFF, 32'h1);
    tick(); idle();
    check("add_result", bus.ALUResult, 32'h8000_0000);
    check("add_flags", 32'(bus.ALUFlags), 32'b1001);
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_illegal", 32'(bus.illegal), 32'd0);
    tick();
    check("add_pulse_once", 32'(bus.out_valid), 32'd0);

    // sub with N,Z-only write, then full write
    op(3'b001, 1'b0, 2'b10, 32'd5, 32'd5);
    tick(); idle();
    check("sub_nz_result", bus.ALUResult, 32'h0);
    check("sub_nz_flags", 32'(bus.ALUFlags), 32'b0101);
    op(3'b001, 1'b0, 2'b11, 32'd5, 32'd5);
    tick(); idle();
    check("sub_all_flags", 32'(bus.ALUFlags), 32'b0110);

    // mul 7*6: ready low 32 cycles, completion 33 cycles after accept cycle
    op(3'b010, 1'b0, 2'b11, 32'd7, 32'd6);
    tick(); idle();
    check("mul_ready_low", 32'(bus.ready), 32'd0);
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      tick();
      if (bus.ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
    end
    check("mul_busy_cycles", 32'(bad), 32'd0);
    tick();
    check("mul_valid", 32'(bus.out_valid), 32'd1);
    check("mul_ready_back", 32'(bus.ready), 32'd1);
    check("mul_result", bus.ALUResult, 32'd42);
    check("mul_flags", 32'(bus.ALUFlags), 32'b0000);
    tick();
    check("mul_pulse_once", 32'(bus.out_valid), 32'd0);

    // all-ones squared wraps to 1
    op(3'b010, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); idle();
    repeat (32) tick();
    check("mul_ff_valid", 32'(bus.out_valid), 32'd1);
    check("mul_ff_result", bus.ALUResult, 32'h1);

    // shifts use only the low 5 bits of SrcB
    op(3'b011, 1'b0, 2'b11, 32'h1, 32'h3F);
    tick();
    check("sll_result", bus.ALUResult, 32'h8000_0000);
    check("sll_flags", 32'(bus.ALUFlags), 32'b1000);
    op(3'b111, 1'b0, 2'b11, 32'h8000_0000, 32'd31);
    tick(); idle();
    check("srl_result", bus.ALUResult, 32'h1);
    check("srl_flags", 32'(bus.ALUFlags), 32'b0000);

    // back-to-back stream: add, sub, illegal opcode, ALUSel=1
    op(3'b000, 1'b0, 2'b11, 32'd1, 32'd2);
    tick();
    check("s0_valid", 32'(bus.out_valid), 32'd1);
    check("s0_result", bus.ALUResult, 32'd3);
    op(3'b001, 1'b0, 2'b11, 32'd3, 32'd5);
    tick();
    check("s1_valid", 32'(bus.out_valid), 32'd1);
    check("s1_result", bus.ALUResult, 32'hFFFF_FFFE);
    check("s1_flags", 32'(bus.ALUFlags), 32'b1000);
    op(3'b101, 1'b0, 2'b11, 32'd9, 32'd9);
    tick();
    check("s2_valid", 32'(bus.out_valid), 32'd1);
    check("s2_illegal", 32'(bus.illegal), 32'd1);
    check("s2_result", bus.ALUResult, 32'h0);
    check("s2_flags", 32'(bus.ALUFlags), 32'b1000);
    op(3'b000, 1'b1, 2'b11, 32'd9, 32'd9);
    tick(); idle();
    check("s3_valid", 32'(bus.out_valid), 32'd1);
    check("s3_illegal", 32'(bus.illegal), 32'd1);
    check("s3_result", bus.ALUResult, 32'h0);
    check("s3_flags", 32'(bus.ALUFlags), 32'b1000);
    tick();
    check("s_end_valid", 32'(bus.out_valid), 32'd0);

    // an op presented together with flush is not accepted
    op(3'b000, 1'b0, 2'b11, 32'd1, 32'd1);
    bus.flush = 1'b1;
    tick(); idle();
    bus.flush = 1'b0;
    check("flush_idle_valid", 32'(bus.out_valid), 32'd0);
    check("flush_idle_result", bus.ALUResult, 32'h0);

    // flush while cnt==10
    op(3'b010, 1'b0, 2'b11, 32'd7, 32'd6);
    tick(); idle();
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush10_ready", 32'(bus.ready), 32'd1);
    check("flush10_valid", 32'(bus.out_valid), 32'd0);
    check("flush10_result", bus.ALUResult, 32'h0);
    check("flush10_flags", 32'(bus.ALUFlags), 32'b1000);
    bad = 0;
    repeat (30) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    check("flush10_no_late", 32'(bad), 32'd0);

    // flush on the final iteration still wins
    op(3'b010, 1'b0, 2'b11, 32'd7, 32'd6);
    tick(); idle();
    repeat (31) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_last_valid", 32'(bus.out_valid), 32'd0);
    check("flush_last_result", bus.ALUResult, 32'h0);
    check("flush_last_ready", 32'(bus.ready), 32'd1);

    // asynchronous reset mid-mul
    op(3'b001, 1'b0, 2'b11, 32'd0, 32'd1);
    tick();
    check("pre_rst_result", bus.ALUResult, 32'hFFFF_FFFF);
    op(3'b010, 1'b0, 2'b11, 32'd3, 32'd3);
    tick(); idle();
    repeat (5) tick();
    #3 reset = 1'b1;
    #1;
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_result", bus.ALUResult, 32'h0);
    check("arst_flags", 32'(bus.ALUFlags), 32'h0);
    check("arst_illegal", 32'(bus.illegal), 32'd0);
    #2 reset = 1'b0;
    bad = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    check("arst_no_late", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
